// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver feeding a byte FIFO push/data_in port.
// A two-flop synchroniser produces rx_s, and every decision uses rx_s only.
// A start bit is validated at mid-bit. Each data bit and the stop bit are
// sampled once per CLKS_PER_BIT after that point. A good byte is presented
// with a one-cycle push. A byte that arrives while the FIFO is full raises
// overrun instead of push. A low stop bit raises frame_err, and the receiver
// then waits for the line to return high before it looks for a new frame.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       full,
    output logic [7:0] data_out,
    output logic       push,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    // Outcome decided at the stop-bit sample, emitted on the following edge.
    typedef enum logic [1:0] {
        RES_NONE,
        RES_PUSH,
        RES_OVR,
        RES_FERR
    } result_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sh_q;
    result_t       res_q;
    logic [7:0]    data_out_q;
    logic          push_q;
    logic          frame_err_q;
    logic          overrun_q;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame state machine, shift register and registered output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            res_q       <= RES_NONE;
            data_out_q  <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            res_q       <= RES_NONE;

            // The outcome is registered in res_q first and turned into a
            // pulse one edge later. That edge is the "next cycle" after the
            // stop-bit sample. sh_q cannot change in the meantime, because
            // a new frame needs at least half a bit before its first data
            // sample.
            case (res_q)
                RES_PUSH: begin
                    push_q     <= 1'b1;
                    data_out_q <= sh_q;
                end
                RES_OVR:  overrun_q   <= 1'b1;
                RES_FERR: frame_err_q <= 1'b1;
                default:  ;
            endcase

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q       <= '0;
                        sh_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            res_q   <= full ? RES_OVR : RES_PUSH;
                            state_q <= IDLE;
                        end else begin
                            res_q   <= RES_FERR;
                            state_q <= BRK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                BRK: begin
                    // A line held low must go high again before a new start bit counts.
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign push      = push_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- 8N1 UART receiver that sits directly upstream of the byte FIFO and feeds its push/data_in interface.
- Recovers bytes from an asynchronous serial line using a fixed clock-per-bit divider.
- Presents each good byte with a single-cycle push pulse; never pushes while the FIFO reports full.
- Flags framing errors and overruns as one-cycle pulses for status counters or LEDs on the ECP5 board.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per serial bit (12 MHz / 115200). Legal range 4..65535; counter width = clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- rx  input  1  asynchronous serial line, idle high
- full  input  1  FIFO full flag, sampled combinationally in the stop-bit cycle
- data_out  output  8  received byte; connects to FIFO data_in; held stable between pushes
- push  output  1  one-cycle strobe; connects to FIFO push
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte dropped because full=1

Behaviour:
- Interface (already decided): one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - data_out=8'h00; push=0; frame_err=0; overrun=0.
  - State=IDLE; bit counter=0; clock counter=0.
  - Both synchroniser flops=1.
  - Reset asserted mid-frame aborts the frame with no push and no error pulse.
- Input sync: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- State machine; one clock counter cnt, one bit index idx (0..7), one shift register sh[7:0]:
  - IDLE: on rx_s==0 go to START with cnt=0.
  - START: cnt counts up. At cnt==CLKS_PER_BIT/2-1 (integer divide) sample rx_s.
    - rx_s==0: go to DATA with cnt=0, idx=0.
    - rx_s==1: glitch; return to IDLE with no pulses.
  - DATA: at cnt==CLKS_PER_BIT-1, sh[idx]<=rx_s (LSB first), cnt<=0.
    - idx==7: go to STOP.
    - Otherwise idx<=idx+1.
  - STOP: at cnt==CLKS_PER_BIT-1 sample rx_s.
    - rx_s==1 and full==0: next cycle push=1 and data_out=sh; go to IDLE.
    - rx_s==1 and full==1: next cycle overrun=1, push stays 0, data_out unchanged; go to IDLE.
    - rx_s==0: next cycle frame_err=1, no push; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering endless frames.
- Pulses: push, frame_err and overrun are registered, high for exactly one clk, and mutually exclusive.
- data_out changes only in the cycle push rises and holds until the next push.
- Latency: push is asserted on the clock edge 2 + 1 + (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT + 1 cycles after the first clk edge that sees rx low. Required tolerance is ±1 clk.
- Back-to-back frames: a new start bit detected in IDLE one cycle after STOP is accepted. The stop bit is sampled mid-bit, so the half bit left over absorbs up to ±4% baud mismatch.
- Push/pop interaction: push is never asserted when full=1. The FIFO gives push priority over pop, so a push here is always accepted by it.
- rx changes outside sample points are ignored. Only the start-bit falling edge and the mid-bit samples matter.

Test Plan:
- CLKS_PER_BIT=8. Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with full=0. Required: exactly one push pulse at 2+1+4+72+1=80 clks ±1 after rx falls, data_out=0xA5, no error pulses.
- CLKS_PER_BIT=8. Drive rx low for 2 clks then high. Required: no push, no frame_err, state back in IDLE. A following 0x3C frame is received correctly.
- Send 0x81 with the stop bit driven 0, then hold rx low for 40 clks. Required: frame_err pulses once, push=0 throughout, and no further activity until rx returns high. A following 0x55 frame then pushes 0x55.
- Hold full=1 and send 0x7E. Required: overrun pulses once, push never rises, data_out keeps its previous value. Deassert full and send 0x7E again: required push with data_out=0x7E.
- Send 0x00 and 0xFF back to back with no idle gap, into the FIFO model. Required: two pushes 80 clks apart (10 bits × 8), FIFO pops return 0x00 then 0xFF.
- Assert reset for 1 clk during the 4th data bit of 0xC3, then send 0x5A. Required: no push for the aborted frame, all outputs reset to zero, and 0x5A is received and pushed correctly.
